// File: rtl/jtvigil_pcm_fetch.sv
// rtl/jtvigil_pcm_fetch.sv - two-line PCM sample word buffer with sequential prefetch
module jtvigil_pcm_fetch #(
    parameter int AW       = 16,
    parameter int PREFETCH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pcm_cs,
    input  logic [AW-1:0] pcm_addr,
    output logic [7:0]    pcm_data,
    output logic          pcm_ok,
    output logic          ext_req,
    output logic [AW-2:0] ext_addr,
    input  logic          ext_ack,
    input  logic [15:0]   ext_data
);
    localparam logic [AW-2:0] WORD_ONE = {{(AW-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DEMAND, PREF, GAP} state_t;

    state_t        state, state_nx;
    logic [1:0]    valid;
    logic [AW-2:0] tag  [2];
    logic [15:0]   data [2];
    logic          mru, victim;

    logic [AW-2:0] word, tag_hit, next_word, fill_addr;
    logic          hit0, hit1, any_hit, next_present;
    logic [15:0]   sel_word;
    logic          start_fill, fill_victim;

    assign word         = pcm_addr[AW-1:1];
    assign hit0         = valid[0] && (tag[0] == word);
    assign hit1         = valid[1] && (tag[1] == word);
    assign any_hit      = hit0 | hit1;
    assign tag_hit      = hit1 ? tag[1] : tag[0];
    assign next_word    = tag_hit + WORD_ONE;
    assign next_present = (valid[0] && (tag[0] == next_word)) ||
                          (valid[1] && (tag[1] == next_word));
    assign sel_word     = hit1 ? data[1] : data[0];
    assign pcm_data     = pcm_addr[0] ? sel_word[15:8] : sel_word[7:0];
    assign pcm_ok       = pcm_cs && any_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Demand misses evict the line not recently hit; prefetches evict the line not hit now.
    always_comb begin
        state_nx    = state;
        start_fill  = 1'b0;
        fill_victim = ~mru;
        fill_addr   = word;
        case (state)
            IDLE: begin
                if (pcm_cs && !any_hit) begin
                    state_nx   = DEMAND;
                    start_fill = 1'b1;
                end else if ((PREFETCH != 0) && pcm_cs && any_hit && !next_present) begin
                    state_nx    = PREF;
                    start_fill  = 1'b1;
                    fill_victim = hit0;
                    fill_addr   = next_word;
                end
            end
            DEMAND, PREF: if (ext_ack) state_nx = GAP;
            GAP:          state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    always_comb begin
        ext_req = 1'b0;
        if (state == DEMAND || state == PREF) ext_req = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 2'b00;
            tag[0]   <= '0;
            tag[1]   <= '0;
            data[0]  <= '0;
            data[1]  <= '0;
            mru      <= 1'b0;
            victim   <= 1'b0;
            ext_addr <= '0;
        end else begin
            if (any_hit) mru <= hit1;
            if (start_fill) begin
                victim             <= fill_victim;
                ext_addr           <= fill_addr;
                valid[fill_victim] <= 1'b0;
            end
            if (ext_req && ext_ack) begin
                valid[victim] <= 1'b1;
                tag[victim]   <= ext_addr;
                data[victim]  <= ext_data;
            end
        end
    end
endmodule

// File: doc/jtvigil_pcm_fetch.md
# jtvigil_pcm_fetch

Responder side of the sound board's PCM sample-ROM port. The sound CPU logic is the initiator: it drives a byte address and waits for a rising `pcm_ok` after each address step. This block answers those requests from a two-line, 16-bit word buffer and refills the buffer over a request/acknowledge ROM bus. It prefetches the next sequential word so that streaming playback hits without stalls.

## Interface
Parameters:
- `AW`, 16: byte address width of the PCM port. The ROM bus word address is `AW-1` bits.
- `PREFETCH`, 1: 1 enables next-word prefetch; 0 means demand fetch only.

Ports:
- `clk`  in  1: system clock. This is the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pcm_cs`  in  1: port enable. When low, no new fetches start and `pcm_ok` is 0.
- `pcm_addr`  in  AW: byte address from the initiator.
- `pcm_data`  out  8: byte at `pcm_addr`. Valid whenever `pcm_ok`=1.
- `pcm_ok`  out  1: current `pcm_addr` hits a valid line.
- `ext_req`  out  1: ROM bus request. Held high until acknowledged.
- `ext_addr`  out  AW-1: ROM bus word address. Stable while `ext_req`=1.
- `ext_ack`  in  1: one-cycle pulse. `ext_data` is valid in that cycle.
- `ext_data`  in  16: ROM word. Bits [7:0] hold the even byte, bits [15:8] the odd byte.

## Operation
Storage: lines L0 and L1. Each line holds a tag (AW-1 bits), a valid bit and a 16-bit data word. The block also keeps a most-recently-hit pointer, `mru`.

Hit logic is combinational from `pcm_addr`:
- `hit_i` = `valid_i` and (`tag_i` = `pcm_addr[AW-1:1]`).
- `pcm_ok` = `pcm_cs` and (`hit0` or `hit1`). The initiator samples `pcm_ok` in the same cycle it presents a new address, so `pcm_ok` must not be registered.
- `pcm_data` = the byte selected by `pcm_addr[0]` from the hitting line.
- With no hit, `pcm_data` = the L0 byte. Its value is don't-care but deterministic.
- `mru` updates to the hitting line on every cycle with a hit.

FSM states:
- IDLE:
  - `pcm_cs` and no hit → DEMAND. Latch `ext_addr`=`pcm_addr[AW-1:1]` and set the victim to the line that is not `mru`.
  - Otherwise, if `PREFETCH`, a hit exists, and word `tag_hit+1` (modulo 2^(AW-1)) is in neither line → PREF. Latch `ext_addr`=`tag_hit+1` and set the victim to the line that did not hit.
  - Otherwise stay in IDLE.
- DEMAND / PREF:
  - `ext_req`=1.
  - On `ext_ack`: write `ext_data` to the victim, set its tag to `ext_addr` and its valid bit to 1, then → GAP.
  - A line being filled has its valid bit cleared on entry to DEMAND/PREF, so it cannot produce a stale hit.
- GAP: one cycle with `ext_req`=0, then → IDLE.

Boundary rules:
- Address change during DEMAND or PREF: the request is never aborted. It completes, and the new address is evaluated in IDLE.
- `ext_ack` in the same cycle as an address change: the fill completes, and the hit status is re-evaluated on the next cycle.
- Word address wrap: the prefetch of word 2^(AW-1)-1 targets word 0.
- Both lines hit: impossible, because tags are unique. A fill never creates a duplicate, since the prefetch check excludes words already present.
- `pcm_cs` falling mid-request: the request still completes, then the FSM stays in IDLE.
- `ext_ack` outside DEMAND/PREF: ignored.

Reset (asynchronous, `rst_n`=0):
- State = IDLE.
- Both valid bits = 0. Tags and data = 0.
- `mru` = 0.
- `ext_req` = 0, `ext_addr` = 0.
- Resulting outputs: `pcm_ok` = 0, `pcm_data` = 0.
- Reset mid-request drops `ext_req` immediately. The ROM bus must tolerate an abandoned request.

## Timing
- Hit: `pcm_ok`/`pcm_data` are valid in the same cycle as `pcm_addr`. The latency is zero cycles.
- Miss: the address is presented at cycle 0 and `ext_req` rises at cycle 1.
  - With `ext_ack` at cycle n, the line is written at the end of cycle n.
  - `pcm_ok`=1 from cycle n+1.
- Prefetch after a demand fill: GAP occupies cycle n+1, IDLE is cycle n+2, and `ext_req` rises at cycle n+3.
- Between two requests, `ext_req` is low for at least 2 cycles.
- With an immediate `ext_ack`, miss-to-ok is 2 cycles.

## Test plan
- Reset, then `pcm_addr`=0x1234 and `pcm_cs`=1 → `pcm_ok`=0 at cycle 0; `ext_req`=1 with `ext_addr`=0x091A at cycle 1.
  - Ack with data 0xBEEF → `pcm_ok`=1 and `pcm_data`=0xEF next cycle. Changing to 0x1235 gives 0xEF→0xBE with no new fetch.
- After the first fill → a prefetch of 0x091B is issued within 3 cycles. Stepping to 0x1236 after its ack → `pcm_ok`=1 at once, and a prefetch of 0x091C follows.
- Sequential stream of 64 bytes with a 4-cycle ack latency, stepping every 40 cycles → `pcm_ok`=1 in the cycle of every step after the first, and data matches the ROM model.
- `pcm_addr`=0xFFFE → the prefetch targets word 0x0000. Stepping to 0x0000 then hits.
- Jump to 0x8000 while PREF is in flight → the prefetch completes, then DEMAND fetches 0x4000, and `pcm_ok` stays 0 until that fill.
- `rst_n` pulsed low while `ext_req`=1 → `ext_req`=0, `pcm_ok`=0, and a late `ext_ack` is ignored. The next access refetches.
